// File: rtl/sd_bd_queue_pkg.sv
// Shared definitions for the SD buffer-descriptor queue.
// Holds the default descriptor depth, descriptor word width, the bit
// positions of the free/used fields inside the status word, and the
// descriptor-assembly phase type.
package sd_bd_queue_pkg;

    localparam int unsigned BD_SIZE       = 8;
    localparam int unsigned RAM_MEM_WIDTH = 32;

    // Bd_Status_reg layout: {free count, used count}
    localparam int unsigned STATUS_FREE_MSB = 15;
    localparam int unsigned STATUS_FREE_LSB = 8;
    localparam int unsigned STATUS_USED_MSB = 7;
    localparam int unsigned STATUS_USED_LSB = 0;

    // Which descriptor word the next we_m_i strobe carries
    typedef enum logic {
        PhWord0 = 1'b0,
        PhWord1 = 1'b1
    } phase_e;

endpackage

// File: rtl/sd_bd_queue_if.sv
// Bus-side signal bundle of the buffer-descriptor queue.
//   master : bus register stage / data master (drives writes, flush, pop)
//   slave  : the queue (drives head descriptor, status and flags)
interface sd_bd_queue_if #(
    parameter int unsigned DW = 32
);
    logic          we_m_i;
    logic [DW-1:0] dat_m_i;
    logic          clr_i;
    logic          ovf_clr_i;
    logic          bd_pop_i;
    logic          bd_valid_o;
    logic [DW-1:0] bd_sys_adr_o;
    logic [DW-1:0] bd_card_adr_o;
    logic [15:0]   bd_status_o;
    logic          ovf_o;
    logic          half_o;

    modport master (
        output we_m_i, dat_m_i, clr_i, ovf_clr_i, bd_pop_i,
        input  bd_valid_o, bd_sys_adr_o, bd_card_adr_o, bd_status_o, ovf_o, half_o
    );

    modport slave (
        input  we_m_i, dat_m_i, clr_i, ovf_clr_i, bd_pop_i,
        output bd_valid_o, bd_sys_adr_o, bd_card_adr_o, bd_status_o, ovf_o, half_o
    );
endinterface

// File: rtl/sd_bd_ram.sv
// Descriptor storage: DEPTH x WIDTH register file.
//   clk   : write clock
//   we    : write enable, writes wdata to waddr on the rising edge
//   raddr : asynchronous read address, rdata follows it combinationally
// Contents are intentionally not reset.
module sd_bd_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sd_bd_queue.sv
// SD host buffer-descriptor queue.
// Assembles two-word descriptors {system address, card block address}
// from successive we_m_i strobes and queues them for the data master.
//   wb_clk_i   : clock (rising edge)
//   wb_rst_n_i : asynchronous active-low reset
//   bus        : queue side of sd_bd_queue_if (writes, flush, pop in;
//                head descriptor, status, overflow and half flags out)
module sd_bd_queue
    import sd_bd_queue_pkg::*;
#(
    parameter int unsigned BD_DEPTH = BD_SIZE,
    parameter int unsigned DW       = RAM_MEM_WIDTH
) (
    input logic         wb_clk_i,
    input logic         wb_rst_n_i,
    sd_bd_queue_if.slave bus
);

    localparam int unsigned AW = (BD_DEPTH > 2) ? $clog2(BD_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = BD_DEPTH[AW:0];
    localparam logic [7:0]  DEPTH_8   = BD_DEPTH[7:0];

    phase_e        phase_q, phase_d;
    logic [DW-1:0] staging_q, staging_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   used_q, used_d;
    logic          ovf_q, ovf_d;

    logic complete, pop_ok, full, accept, drop;
    logic [2*DW-1:0] head;
    logic [7:0] used_8;

    assign complete = bus.we_m_i && (phase_q == PhWord1);
    assign pop_ok   = bus.bd_pop_i && (used_q != '0);
    assign full     = (used_q == DEPTH_CNT);
    // When full, a same-cycle pop frees the slot at the write pointer
    // (it equals the read pointer) exactly as the new descriptor lands.
    assign accept   = complete && (!full || pop_ok);
    assign drop     = complete && full && !pop_ok;

    always_comb begin
        phase_d   = phase_q;
        staging_d = staging_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        used_d    = used_q;
        ovf_d     = ovf_q;

        if (bus.clr_i) begin
            phase_d   = PhWord0;
            staging_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            used_d    = '0;
            ovf_d     = 1'b0;
        end else begin
            if (bus.we_m_i) begin
                if (phase_q == PhWord0) begin
                    staging_d = bus.dat_m_i;
                    phase_d   = PhWord1;
                end else begin
                    phase_d = PhWord0;
                end
            end
            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (accept && !pop_ok) begin
                used_d = used_q + 1'b1;
            end else if (!accept && pop_ok) begin
                used_d = used_q - 1'b1;
            end
            // A fresh overflow beats a simultaneous clear request
            if (drop) begin
                ovf_d = 1'b1;
            end else if (bus.ovf_clr_i) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            phase_q   <= PhWord0;
            staging_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            staging_q <= staging_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
            ovf_q     <= ovf_d;
        end
    end

    // Only completed descriptors are written, so a half-built one never
    // reaches the head.
    sd_bd_ram #(
        .DEPTH (BD_DEPTH),
        .WIDTH (2 * DW),
        .AW    (AW)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (accept && !bus.clr_i),
        .waddr (wr_ptr_q),
        .wdata ({staging_q, bus.dat_m_i}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign used_8 = 8'(used_q);

    assign bus.bd_valid_o    = (used_q != '0);
    assign bus.bd_sys_adr_o  = head[2*DW-1:DW];
    assign bus.bd_card_adr_o = head[DW-1:0];
    assign bus.bd_status_o[STATUS_FREE_MSB:STATUS_FREE_LSB] = DEPTH_8 - used_8;
    assign bus.bd_status_o[STATUS_USED_MSB:STATUS_USED_LSB] = used_8;
    assign bus.ovf_o         = ovf_q;
    assign bus.half_o        = (phase_q == PhWord1);

endmodule

// File: tb/tb_sd_bd_queue.sv
module tb_sd_bd_queue;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] sb[$];
    logic        m_phase;
    logic [31:0] m_stg;
    logic        m_ovf;

    sd_bd_queue_if #(.DW(32)) bus ();

    sd_bd_queue #(
        .BD_DEPTH (8),
        .DW       (32)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_phase = 1'b0;
        m_stg   = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_state();
        int n;
        n = sb.size();
        chk("used_bound", 32'(n <= 8), 32'd1);
        chk("valid", 32'(bus.bd_valid_o), 32'(n != 0));
        chk("status", 32'(bus.bd_status_o), {16'h0, 8'(8 - n), 8'(n)});
        chk("half", 32'(bus.half_o), 32'(m_phase));
        chk("ovf", 32'(bus.ovf_o), 32'(m_ovf));
        if (n != 0) begin
            chk("head_sys", bus.bd_sys_adr_o, sb[0][63:32]);
            chk("head_card", bus.bd_card_adr_o, sb[0][31:0]);
        end
    endtask

    // One clock of stimulus; the scoreboard is updated from the inputs and
    // then every output is compared 1 ns after the edge.
    task automatic step(input logic we, input logic [31:0] dat, input logic pop,
                        input logic clr, input logic oc);
        int   n;
        logic pop_ok;
        logic drop;
        @(negedge clk);
        bus.we_m_i    = we;
        bus.dat_m_i   = dat;
        bus.bd_pop_i  = pop;
        bus.clr_i     = clr;
        bus.ovf_clr_i = oc;
        n      = sb.size();
        pop_ok = pop && (n != 0);
        drop   = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            if (pop_ok) void'(sb.pop_front());
            if (we) begin
                if (!m_phase) begin
                    m_stg   = dat;
                    m_phase = 1'b1;
                end else begin
                    m_phase = 1'b0;
                    if (n < 8 || pop_ok) sb.push_back({m_stg, dat});
                    else drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.we_m_i    = 1'b0;
        bus.dat_m_i   = '0;
        bus.bd_pop_i  = 1'b0;
        bus.clr_i     = 1'b0;
        bus.ovf_clr_i = 1'b0;
        check_state();
    endtask

    task automatic put(input logic [31:0] sys, input logic [31:0] card);
        step(1'b1, sys, 1'b0, 1'b0, 1'b0);
        step(1'b1, card, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] last_sys;
        bus.we_m_i    = 1'b0;
        bus.dat_m_i   = '0;
        bus.bd_pop_i  = 1'b0;
        bus.clr_i     = 1'b0;
        bus.ovf_clr_i = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #17;
        check_state();
        chk("rst_status", 32'(bus.bd_status_o), 32'h0800);
        rst_n = 1'b1;

        // First descriptor
        step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
        chk("half_after_w0", 32'(bus.half_o), 32'd1);
        chk("no_early_head", 32'(bus.bd_valid_o), 32'd0);
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
        chk("first_sys", bus.bd_sys_adr_o, 32'h0000_1000);
        chk("first_card", bus.bd_card_adr_o, 32'h0000_0040);
        chk("first_status", 32'(bus.bd_status_o), 32'h0701);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Fill, then overflow with a 9th descriptor
        for (int k = 1; k <= 8; k++) put(32'h0001_0000 + k, 32'h0002_0000 + k);
        put(32'h0001_0009, 32'h0002_0009);
        chk("ovf_set", 32'(bus.ovf_o), 32'd1);
        chk("full_status", 32'(bus.bd_status_o), 32'h0008);
        chk("head_d1", bus.bd_sys_adr_o, 32'h0001_0001);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(bus.ovf_o), 32'd0);

        // 9th completes in the same cycle as a pop while full
        step(1'b1, 32'h0001_0009, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0002_0009, 1'b1, 1'b0, 1'b0);
        chk("pop_full_no_ovf", 32'(bus.ovf_o), 32'd0);
        chk("pop_full_status", 32'(bus.bd_status_o), 32'h0008);
        chk("head_d2", bus.bd_sys_adr_o, 32'h0001_0002);
        last_sys = '0;
        while (sb.size() != 0) begin
            last_sys = bus.bd_sys_adr_o;
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("ninth_last", last_sys, 32'h0001_0009);

        // Pointer wrap with concurrent push/pop
        for (int k = 0; k < 3; k++) put($urandom, $urandom);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
            if (k == 7) begin
                // overflow clear and a new overflow together: overflow wins
                for (int j = 0; j < 5; j++) put($urandom, $urandom);
                step(1'b1, 32'hdead_0000, 1'b0, 1'b0, 1'b0);
                step(1'b1, 32'hdead_0001, 1'b0, 1'b0, 1'b1);
                chk("ovf_wins", 32'(bus.ovf_o), 32'd1);
                step(1'b0, '0, 1'b0, 1'b0, 1'b1);
                for (int j = 0; j < 5; j++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            end
        end
        while (sb.size() != 0) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with a staged word, and flush beating a completion plus pop
        put(32'h0000_0aaa, 32'h0000_0bbb);
        step(1'b1, 32'h0000_0ccc, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_half", 32'(bus.half_o), 32'd0);
        chk("clr_status", 32'(bus.bd_status_o), 32'h0800);
        put(32'h0000_0111, 32'h0000_0222);
        step(1'b1, 32'h0000_0333, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0444, 1'b1, 1'b1, 1'b0);
        chk("clr_wins", 32'(bus.bd_status_o), 32'h0800);
        put(32'h0000_0555, 32'h0000_0666);
        chk("fresh_sys", bus.bd_sys_adr_o, 32'h0000_0555);
        chk("fresh_card", bus.bd_card_adr_o, 32'h0000_0666);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Pop while empty, then reset in the middle of a descriptor
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("empty_pop_status", 32'(bus.bd_status_o), 32'h0800);
        step(1'b1, 32'h0000_a5a5, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        check_state();
        put(32'h0000_000b, 32'h0000_000c);
        chk("post_rst_sys", bus.bd_sys_adr_o, 32'h0000_000b);
        chk("post_rst_card", bus.bd_card_adr_o, 32'h0000_000c);
        chk("post_rst_status", 32'(bus.bd_status_o), 32'h0701);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_bd_queue.md
SD_BD_QUEUE -- requirements
Module: sd_bd_queue

Interface
REQ-001 SHALL have parameter BD_DEPTH, default 8 (`BD_SIZE in sd_defines.v), meaning descriptor slots; power of two, 2..128.
REQ-002 SHALL have parameter DW, default 32 (`RAM_MEM_WIDTH), meaning width of one descriptor word.
REQ-003 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 we_m_i  in  1  one-cycle strobe: dat_m_i holds one descriptor word from the bus register stage.
REQ-006 dat_m_i  in  DW  descriptor word; first word is the system memory address, second word is the card block address.
REQ-007 clr_i  in  1  synchronous queue flush (software reset).
REQ-008 ovf_clr_i  in  1  clears the overflow flag.
REQ-009 bd_pop_i  in  1  consumer (data master) retires the head descriptor.
REQ-010 bd_valid_o  out  1  queue non-empty; head outputs meaningful.
REQ-011 bd_sys_adr_o  out  DW  head descriptor word 0.
REQ-012 bd_card_adr_o  out  DW  head descriptor word 1.
REQ-013 bd_status_o  out  16  {free count[15:8], used count[7:0]}, feeds Bd_Status_reg.
REQ-014 ovf_o  out  1  sticky: a completed descriptor was dropped because the queue was full.
REQ-015 half_o  out  1  word 0 staged, waiting for word 1.

Function
REQ-016 A one-bit phase SHALL select the target of each we_m_i: phase 0 loads word 0 into a staging register and sets phase; phase 1 completes the descriptor and clears phase.
REQ-017 Completion SHALL write {staging, dat_m_i} into the slot at the write pointer, advance the write pointer modulo BD_DEPTH and increment used, in the same edge.
REQ-018 Completion while used==BD_DEPTH and no accepted pop SHALL drop the descriptor, set ovf_o, clear phase, and leave pointers and count unchanged.
REQ-019 Completion and accepted pop in the same cycle while full SHALL be accepted; used stays BD_DEPTH.
REQ-020 bd_pop_i with bd_valid_o=1 SHALL advance the read pointer modulo BD_DEPTH and decrement used on that edge; bd_pop_i while empty SHALL be ignored.
REQ-021 Simultaneous completion and pop when not full or empty SHALL leave used unchanged and move both pointers.
REQ-022 Head outputs SHALL be combinational reads of the slot at the read pointer (zero latency); bd_valid_o = (used != 0).
REQ-023 Free count SHALL be BD_DEPTH - used; both fields zero-extended to 8 bits.
REQ-024 clr_i SHALL zero pointers, used, phase, staging and ovf_o in one cycle; it wins over a simultaneous write or pop; slot contents are don't-care.
REQ-025 ovf_clr_i SHALL clear ovf_o; a simultaneous new overflow SHALL win (ovf_o stays 1).
REQ-026 Word 1 of an in-progress descriptor SHALL never be visible at the head before completion.

Reset
REQ-027 On wb_rst_n_i low, asynchronously: pointers 0, used 0, phase 0, staging 0, ovf_o 0; hence bd_valid_o 0, half_o 0, bd_status_o = {BD_DEPTH, 8'h00}.
REQ-028 Reset mid-descriptor SHALL discard the staged word; the next we_m_i after release is word 0.
REQ-029 Storage array SHALL not be reset.

Structure
REQ-030 BD_SIZE, RAM_MEM_WIDTH and the status field positions SHALL be defined in shared sd_defines.v, not locally.
REQ-031 Storage SHALL be a sub-module sd_bd_ram: BD_DEPTH x 2*DW register file, one synchronous write port, one asynchronous read port.
REQ-032 Pointer/count/phase control SHALL reside in sd_bd_queue; used counter width log2(BD_DEPTH)+1.

Verification
REQ-033 Reset release, then we_m_i with 32'h0000_1000 then 32'h0000_0040 -> next cycle bd_valid_o=1, sys=32'h1000, card=32'h40, bd_status_o=16'h0701.
REQ-034 Write 8 descriptors, then a 9th pair -> ovf_o=1, bd_status_o=16'h0008, head still descriptor 1; ovf_clr_i -> ovf_o=0.
REQ-035 Full queue, word 1 of 9th pair in same cycle as bd_pop_i -> no overflow, used=8, head = descriptor 2, 9th retrievable last.
REQ-036 16 push/pop cycles forcing pointer wrap -> FIFO order preserved, data matches model, used never exceeds 8.
REQ-037 Word 0 staged (half_o=1), then clr_i -> half_o=0, used=0; next two writes form a fresh descriptor.
REQ-038 bd_pop_i while empty, and wb_rst_n_i pulsed low mid-descriptor -> no count underflow; status 16'h0800; no stale word appears.
